ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage RISC-V pipeline. It consumes the ID/EX register outputs, selects forwarded operands, and executes the ALU operation. It resolves branches and jumps, driving a PC redirect, and registers its results into the EX/MEM pipeline register. An optional iterative multiplier stalls the upstream pipeline while it runs.

## Interface
Parameters:
- XLEN, 32, datapath width; all data and PC ports are XLEN wide.

Ports (clock is `clk`, reset is `rst`: asynchronous, active-high):
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- id_ex_output_data1, id_ex_output_data_2, id_ex_sign_extend_immediate, id_ex_pc  in  XLEN  operands, immediate, instruction PC
- id_ex_register_rd  in  5  destination register
- id_ex_alu_control  in  4  ALU op
- id_ex_enable, id_ex_alusrc, id_ex_memtoreg, id_ex_memread, id_ex_memwrite, id_ex_regwrite_control, id_ex_branch, id_ex_branch2, id_ex_jump  in  1  valid and control bits
- fwd_a_sel, fwd_b_sel  in  2  operand source: 00 ID/EX, 01 EX/MEM result, 10 MEM/WB data, 11 reserved (treated as 00)
- mem_wb_write_data  in  XLEN  writeback forwarding data
- flush  in  1  kill the instruction in EX and any running multiply
- ex_busy  out  1  stall request to IF/ID and ID/EX
- pc_redirect  out  1  taken branch or jump, combinational
- redirect_target  out  XLEN  id_ex_pc + immediate
- ex_mem_alu_result, ex_mem_write_data  out  XLEN  registered result and store data (forwarded B)
- ex_mem_register_rd  out  5
- ex_mem_valid, ex_mem_memtoreg, ex_mem_memread, ex_mem_memwrite, ex_mem_regwrite_control  out  1

## Operation
- valid_in = id_ex_enable & ~flush. When valid_in is 0, the stage writes a bubble: every ex_mem control bit and ex_mem_valid are 0, and the data outputs hold.
- Operand A = forward mux A. Operand B = immediate if alusrc, else forward mux B. Store data = forward mux B.
- ALU ops: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1010 MUL (low XLEN bits), others → 0.
  - Shift amount is B[4:0].
  - Add and subtract wrap modulo 2^XLEN.
- Branch: taken = valid_in & ((branch & A==B) | (branch2 & A!=B)), using the forwarded register operands.
- Jump: taken = valid_in & jump; the result is id_ex_pc + 4.
- pc_redirect = branch taken | jump taken. It is never asserted while ex_busy is high.
- Multiplier FSM states:
  - IDLE: on valid_in & op==MUL, latch A and B, clear the 5-bit count, go to RUN, ex_busy=1.
  - RUN: one shift-add step per cycle. ex_busy = (count != 31). At count==31, write the product to EX/MEM with ex_mem_valid=1 and return to IDLE.
  - flush in RUN: return to IDLE, write a bubble, deassert ex_busy.
- While ex_busy is high, EX/MEM receives bubbles. Upstream holds ID/EX stable.

## Timing
- Reset values: all ex_mem_* outputs are 0, the FSM is IDLE, ex_busy=0, count=0.
- Reset asserted mid-multiply aborts it with no result.
- Non-MUL ops have 1-cycle latency: the result is visible after the next rising edge.
- MUL issued in cycle T: ex_busy is high in cycles T..T+31 and low in T+32. The result is registered at the edge ending T+32, the same edge at which ID/EX advances. The next instruction is sampled in IDLE at T+33.
- pc_redirect and redirect_target are combinational in the same cycle as the instruction in EX.
- Simultaneous flush and MUL issue: the flush wins, no multiply starts, and ex_busy stays 0.

## Configuration
- EX_MULDIV_EN defined: the multiplier FSM and op 1010 are present.
- EX_MULDIV_EN undefined: op 1010 returns 0 in one cycle, ex_busy is tied to 0, and no FSM is present.

## Structure
- Package ex_pkg holds:
  - ALU op codes as localparams or typedef enum
  - forward select codes
  - FSM state typedef (IDLE, RUN)
- Sub-module ex_alu holds the purely combinational ALU, excluding MUL. ex_stage holds the muxes, branch logic, FSM and EX/MEM register.

## Test plan
- ADD: A=5, B=7, alusrc=0, enable=1 → after 1 edge, ex_mem_alu_result=12 and ex_mem_valid=1.
- Forwarding: fwd_a_sel=01, last result 12, op SUB, B=2 → result 10. fwd_b_sel=10 with mem_wb_write_data=3 and op SLL on A=1 → 8.
- BEQ: A=B=9, branch=1, pc=0x100, imm=0x20 → pc_redirect=1 and redirect_target=0x120 in the same cycle. With branch2=1 instead → pc_redirect=0.
- JAL: jump=1, pc=0x40 → ex_mem_alu_result=0x44 and pc_redirect=1.
- MUL 0xFFFF_FFFF × 3 (EX_MULDIV_EN defined) → ex_busy high for 32 cycles, then result 0xFFFF_FFFD. A flush at RUN count 10 → ex_busy drops and EX/MEM gets a bubble.
- enable=0 and reset mid-RUN → ex_mem_valid=0, all control bits 0, FSM returns to IDLE.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU op codes, forwarding selects,
// multiplier FSM states and the EX/MEM control bundle.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  localparam int MUL_CNT_W = 5;
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = 5'd31;

  typedef struct packed {
    logic valid;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic regwrite;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_alu.sv
// Purely combinational integer ALU for the execute stage; MUL is handled
// by the iterative multiplier in ex_stage and yields 0 here.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (alu_op_e'(alu_control))
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_ADD:  result = op_a + op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SRA:  result = $signed(op_a) >>> shamt;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM register. Define EX_MULDIV_EN to add the iterative shift-add multiplier.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_ex_output_data1,
  input  logic [XLEN-1:0] id_ex_output_data_2,
  input  logic [XLEN-1:0] id_ex_sign_extend_immediate,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [4:0]      id_ex_register_rd,
  input  logic [3:0]      id_ex_alu_control,
  input  logic            id_ex_enable,
  input  logic            id_ex_alusrc,
  input  logic            id_ex_memtoreg,
  input  logic            id_ex_memread,
  input  logic            id_ex_memwrite,
  input  logic            id_ex_regwrite_control,
  input  logic            id_ex_branch,
  input  logic            id_ex_branch2,
  input  logic            id_ex_jump,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] mem_wb_write_data,
  input  logic            flush,
  output logic            ex_busy,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_write_data,
  output logic [4:0]      ex_mem_register_rd,
  output logic            ex_mem_valid,
  output logic            ex_mem_memtoreg,
  output logic            ex_mem_memread,
  output logic            ex_mem_memwrite,
  output logic            ex_mem_regwrite_control
);

  logic            valid_in;
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_result, single_result, mul_product;
  logic            br_taken, jmp_taken, mul_done;
  ex_ctrl_t        ctrl_in, ctrl_d, ctrl_q;
  logic [XLEN-1:0] result_d, result_q, wdata_d, wdata_q;
  logic [4:0]      rd_d, rd_q;

  assign valid_in = id_ex_enable & ~flush;

  // Reserved select 11 falls through to the ID/EX operand.
  always_comb begin
    op_a = id_ex_output_data1;
    case (fwd_sel_e'(fwd_a_sel))
      FWD_EXMEM: op_a = result_q;
      FWD_MEMWB: op_a = mem_wb_write_data;
      default:   op_a = id_ex_output_data1;
    endcase
    fwd_b = id_ex_output_data_2;
    case (fwd_sel_e'(fwd_b_sel))
      FWD_EXMEM: fwd_b = result_q;
      FWD_MEMWB: fwd_b = mem_wb_write_data;
      default:   fwd_b = id_ex_output_data_2;
    endcase
  end

  assign op_b = id_ex_alusrc ? id_ex_sign_extend_immediate : fwd_b;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .alu_control (id_ex_alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (alu_result)
  );

  // Branch compare always uses the forwarded register operands, never the immediate.
  assign br_taken  = valid_in & ((id_ex_branch & (op_a == fwd_b)) |
                                 (id_ex_branch2 & (op_a != fwd_b)));
  assign jmp_taken = valid_in & id_ex_jump;

  assign pc_redirect     = (br_taken | jmp_taken) & ~ex_busy;
  assign redirect_target = id_ex_pc + id_ex_sign_extend_immediate;
  assign single_result   = id_ex_jump ? (id_ex_pc + XLEN'(4)) : alu_result;

`ifdef EX_MULDIV_EN
  mul_state_e             state_q, state_d;
  logic [MUL_CNT_W-1:0]   count_q, count_d;
  logic [XLEN-1:0]        mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [XLEN-1:0]        partial;
  logic                   mul_issue, mul_busy;

  assign mul_issue = valid_in & (id_ex_alu_control == ALU_MUL);
  assign partial   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    mul_busy = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (mul_issue) begin
          state_d  = MUL_RUN;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = '0;
          mul_busy = 1'b1;
        end
      end
      MUL_RUN: begin
        if (flush) begin
          state_d = MUL_IDLE;
          count_d = '0;
        end else begin
          acc_d    = partial;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + MUL_CNT_W'(1);
          if (count_q == MUL_LAST) begin
            mul_done = 1'b1;
            state_d  = MUL_IDLE;
          end else begin
            mul_busy = 1'b1;
          end
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign ex_busy     = mul_busy;
  assign mul_product = partial;
`else
  assign ex_busy     = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  assign ctrl_in = '{valid:    1'b1,
                     memtoreg: id_ex_memtoreg,
                     memread:  id_ex_memread,
                     memwrite: id_ex_memwrite,
                     regwrite: id_ex_regwrite_control};

  // Bubbles clear the control bits but leave the data fields holding.
  always_comb begin
    result_d = result_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    ctrl_d   = '0;
    if (mul_done) begin
      result_d = mul_product;
      wdata_d  = fwd_b;
      rd_d     = id_ex_register_rd;
      ctrl_d   = ctrl_in;
    end else if (valid_in & ~ex_busy) begin
      result_d = single_result;
      wdata_d  = fwd_b;
      rd_d     = id_ex_register_rd;
      ctrl_d   = ctrl_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      result_q <= result_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ex_mem_alu_result       = result_q;
  assign ex_mem_write_data       = wdata_q;
  assign ex_mem_register_rd      = rd_q;
  assign ex_mem_valid            = ctrl_q.valid;
  assign ex_mem_memtoreg         = ctrl_q.memtoreg;
  assign ex_mem_memread          = ctrl_q.memread;
  assign ex_mem_memwrite         = ctrl_q.memwrite;
  assign ex_mem_regwrite_control = ctrl_q.regwrite;

endmodule
